// File: rtl/seg7_pkg.sv
// Shared types and segment encoding for the serial 7-segment display driver.
package seg7_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is left off here and applied by the encoder.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 8'hC0;
      4'h1: hex_to_seg = 8'hF9;
      4'h2: hex_to_seg = 8'hA4;
      4'h3: hex_to_seg = 8'hB0;
      4'h4: hex_to_seg = 8'h99;
      4'h5: hex_to_seg = 8'h92;
      4'h6: hex_to_seg = 8'h82;
      4'h7: hex_to_seg = 8'hF8;
      4'h8: hex_to_seg = 8'h80;
      4'h9: hex_to_seg = 8'h90;
      4'hA: hex_to_seg = 8'h88;
      4'hB: hex_to_seg = 8'h83;
      4'hC: hex_to_seg = 8'hC6;
      4'hD: hex_to_seg = 8'hA1;
      4'hE: hex_to_seg = 8'h86;
      default: hex_to_seg = 8'h8E;
    endcase
  endfunction
endpackage

// File: rtl/seg7_digit_encoder.sv
// One digit: hex + decimal point + blank -> active-low segment byte.
module seg7_digit_encoder
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       point,
  input  logic       blank,
  output logic [7:0] seg
);
  always_comb begin
    seg = hex_to_seg(hex);
    if (point) seg[7] = 1'b0;
    if (blank) seg = SEG_BLANK;
  end
endmodule

// File: rtl/seg7_serial_driver.sv
// Serial driver for a chained shift-register 7-segment display: snapshot, encode,
// shift out MSB (leftmost digit dp) first, then pulse the latch line.
module seg7_serial_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int CLK_DIV      = 2,
  parameter int REFRESH_BITS = 21,
  parameter int FLASH_BITS   = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   hexs,
  input  logic [DIGITS-1:0]     point,
  input  logic [DIGITS-1:0]     les,
  input  logic                  flash_en,
  input  logic                  lz_blank,
  output logic                  busy,
  output logic                  done,
  output logic                  seg_clk,
  output logic                  seg_sout,
  output logic                  seg_pen,
  output logic                  seg_clrn
);
  localparam int NBITS = 8 * DIGITS;
  localparam int BIT_W = $clog2(NBITS);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_e                  state_q, state_d;
  logic                    pending_q, pending_d, half_q, half_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [NBITS-1:0]        shreg_q, shreg_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic                    seg_clk_q, seg_clk_d, seg_sout_q, seg_sout_d;
  logic                    seg_pen_q, seg_pen_d, seg_clrn_q;
  logic [FLASH_BITS-1:0]   flash_q, flash_d;
  logic                    refresh_tick, req, flash_phase;
  logic [DIGITS-1:0]       lz_mask, blank;
  logic [DIGITS-1:0][7:0]  enc;

  generate
    if (REFRESH_BITS > 0) begin : g_refresh
      logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
      assign refresh_d    = refresh_q + 1'b1;
      assign refresh_tick = &refresh_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) refresh_q <= '0;
        else     refresh_q <= refresh_d;
      end
    end else begin : g_no_refresh
      assign refresh_tick = 1'b0;
    end
  endgenerate

  assign flash_d     = flash_q + 1'b1;
  assign flash_phase = flash_q[FLASH_BITS-1];

  // A digit is LZ-blanked only if it and every digit to its left are zero.
  always_comb begin
    logic above_zero;
    above_zero = 1'b1;
    lz_mask    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      above_zero = above_zero & (hexs[4*i +: 4] == 4'h0);
      if (i != 0) lz_mask[i] = lz_blank & above_zero;
    end
    blank = lz_mask | ({DIGITS{flash_en & flash_phase}} & les);
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    seg7_digit_encoder u_enc (
      .hex   (hexs[4*i +: 4]),
      .point (point[i]),
      .blank (blank[i]),
      .seg   (enc[i])
    );
  end

  assign req = start | refresh_tick;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    half_d     = half_q;
    div_d      = div_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    seg_clk_d  = seg_clk_q;
    seg_sout_d = seg_sout_q;
    seg_pen_d  = seg_pen_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = LOAD;
        busy_d  = 1'b1;
      end
      LOAD: begin
        if (req) pending_d = 1'b1;
        state_d    = SHIFT;
        shreg_d    = enc << 1;
        seg_sout_d = enc[DIGITS-1][7];
        seg_clk_d  = 1'b0;
        seg_pen_d  = 1'b0;
        div_d      = '0;
        half_d     = 1'b0;
        bit_d      = '0;
      end
      SHIFT: begin
        if (req) pending_d = 1'b1;
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d = '0;
          if (!half_q) begin
            half_d    = 1'b1;
            seg_clk_d = 1'b1;
          end else if (bit_q == BIT_W'(NBITS - 1)) begin
            state_d    = LATCH;
            seg_pen_d  = 1'b1;
            seg_sout_d = 1'b1;
            done_d     = 1'b1;
          end else begin
            half_d     = 1'b0;
            bit_d      = bit_q + 1'b1;
            seg_clk_d  = 1'b0;
            seg_sout_d = shreg_q[NBITS-1];
            shreg_d    = shreg_q << 1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        // A request arriving in the latch cycle is folded into the pending slot.
        if (pending_q || req) begin
          state_d   = LOAD;
          pending_d = 1'b0;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      half_q     <= 1'b0;
      div_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      seg_clk_q  <= 1'b1;
      seg_sout_q <= 1'b1;
      seg_pen_q  <= 1'b0;
      seg_clrn_q <= 1'b0;
      flash_q    <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      half_q     <= half_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      seg_clk_q  <= seg_clk_d;
      seg_sout_q <= seg_sout_d;
      seg_pen_q  <= seg_pen_d;
      seg_clrn_q <= 1'b1;
      flash_q    <= flash_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign seg_clk  = seg_clk_q;
  assign seg_sout = seg_sout_q;
  assign seg_pen  = seg_pen_q;
  assign seg_clrn = seg_clrn_q;
endmodule

// File: tb/tb_seg7_serial_driver.sv
// Directed bench: serial stream scoreboard on instance a, refresh/CLK_DIV=1 timing on b.
module tb_seg7_serial_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_a = 1'b0, start_b = 1'b0, flash_en = 1'b0, lz_blank = 1'b0;
  logic [31:0] hexs = '0;
  logic [7:0]  point = '0, les = '0;
  logic busy_a, done_a, sclk_a, sout_a, pen_a, clrn_a;
  logic busy_b, done_b, sclk_b, sout_b, pen_b, clrn_b;

  int n_cmp = 0, n_err = 0;
  int rises_a = 0, dones_a = 0, nbits = 0;
  logic       prev_a = 1'b1;
  logic [7:0] byte_a = '0;
  logic [7:0] exp_q[$];
  int unsigned cyc = 0;

  seg7_serial_driver #(.DIGITS(8), .CLK_DIV(2), .REFRESH_BITS(0), .FLASH_BITS(10)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .hexs(hexs), .point(point), .les(les),
    .flash_en(flash_en), .lz_blank(lz_blank), .busy(busy_a), .done(done_a),
    .seg_clk(sclk_a), .seg_sout(sout_a), .seg_pen(pen_a), .seg_clrn(clrn_a));

  seg7_serial_driver #(.DIGITS(8), .CLK_DIV(1), .REFRESH_BITS(8), .FLASH_BITS(24)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .hexs(hexs), .point(point), .les(les),
    .flash_en(1'b0), .lz_blank(1'b0), .busy(busy_b), .done(done_b),
    .seg_clk(sclk_b), .seg_sout(sout_b), .seg_pen(pen_b), .seg_clrn(clrn_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push8(input logic [63:0] b);
    for (int k = 7; k >= 0; k--) exp_q.push_back(b[8*k +: 8]);
  endtask

  // Mirrors the DUT flash counter so frames can be launched in a known phase.
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0; else cyc <= cyc + 1;

  always @(negedge clk) if (done_a) dones_a++;

  // Capture seg_sout on each seg_clk rise and compare whole bytes against the queue.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      nbits  = 0;
      prev_a = 1'b1;
      exp_q.delete();
    end else begin
      if (!prev_a && sclk_a) begin
        rises_a++;
        byte_a = {byte_a[6:0], sout_a};
        nbits++;
        if (nbits == 8) begin
          nbits = 0;
          chk("byte_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) chk("stream_byte", byte_a, exp_q.pop_front());
        end
      end
      prev_a = sclk_a;
    end
  end

  task automatic frame_a(input string tag);
    int cnt, r0, d0;
    r0 = rises_a;
    d0 = dones_a;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    for (cnt = 1; cnt < 2000; cnt++) begin
      @(posedge clk); @(negedge clk);
      if (cnt == 100) begin
        chk({tag, "_pen_shift"}, pen_a, 0);
        chk({tag, "_busy_shift"}, busy_a, 1);
      end
      if (done_a) break;
    end
    chk({tag, "_done_latency"}, cnt, 1 + 16*8*2);
    chk({tag, "_rises"}, rises_a - r0, 64);
    chk({tag, "_pen_latch"}, pen_a, 1);
    repeat (5) @(negedge clk);
    chk({tag, "_pen_idle"}, pen_a, 1);
    chk({tag, "_busy_idle"}, busy_a, 0);
    chk({tag, "_done_count"}, dones_a - d0, 1);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int cnt, d0, r1, nr, t_first, t_second, t_last;
    logic prev_b;
    repeat (2) @(posedge clk); #1;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_seg_clk", sclk_a, 1);
    chk("rst_sout", sout_a, 1);
    chk("rst_pen", pen_a, 0);
    chk("rst_clrn", clrn_a, 0);
    chk("rst_b_outs", {busy_b, done_b, sclk_b, sout_b, pen_b, clrn_b}, 6'b001100);
    @(negedge clk); rst = 1'b0; #1;
    chk("clrn_before_edge", clrn_a, 0);
    @(negedge clk);
    chk("clrn_after_edge", clrn_a, 1);

    hexs = 32'h0123_4567;
    push8(64'hC0F9A4B0_999282F8);
    frame_a("basic");

    lz_blank = 1'b1; hexs = 32'h0000_00A0; point = 8'h01;
    push8(64'hFFFFFFFF_FFFF8840);
    frame_a("lz_a0");
    hexs = 32'h0; point = 8'h00;
    push8(64'hFFFFFFFF_FFFFFFC0);
    frame_a("lz_zero");
    lz_blank = 1'b0;

    flash_en = 1'b1; les = 8'h0F; hexs = 32'h0123_4567;
    for (int k = 0; k < 1100 && (cyc % 1024) != 600; k++) @(negedge clk);
    push8(64'hC0F9A4B0_FFFFFFFF);
    frame_a("flash_on");
    for (int k = 0; k < 1100 && (cyc % 1024) != 100; k++) @(negedge clk);
    push8(64'hC0F9A4B0_999282F8);
    frame_a("flash_off");
    flash_en = 1'b0; les = 8'h00;

    // Two requests during a frame collapse into one follow-on frame; hexs change mid-frame.
    hexs = 32'h89AB_CDEF;
    push8(64'h80908883_C6A1868E);
    d0 = dones_a;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    for (cnt = 1; cnt < 2000; cnt++) begin
      @(posedge clk); @(negedge clk);
      start_a = (cnt == 100) || (cnt == 200);
      if (cnt == 150) begin
        hexs = 32'h7654_3210;
        push8(64'hF8829299_B0A4F9C0);
      end
      if (done_a) break;
    end
    start_a = 1'b0;
    chk("pend_latency1", cnt, 257);
    for (cnt = 1; cnt < 2000; cnt++) begin
      @(posedge clk); @(negedge clk);
      if (done_a) break;
    end
    chk("pend_latency2", cnt, 258);
    repeat (600) @(negedge clk);
    chk("pend_done_total", dones_a - d0, 2);
    chk("pend_idle", busy_a, 0);
    chk("pend_queue_empty", exp_q.size(), 0);

    hexs = 32'h0123_4567;
    push8(64'hC0F9A4B0_999282F8);
    r1 = rises_a; d0 = dones_a;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    for (cnt = 0; cnt < 2000 && (rises_a - r1) < 30; cnt++) @(negedge clk);
    chk("midrst_bit30", rises_a - r1, 30);
    #2 rst = 1'b1; #1;
    chk("midrst_busy", busy_a, 0);
    chk("midrst_done", done_a, 0);
    chk("midrst_seg_clk", sclk_a, 1);
    chk("midrst_sout", sout_a, 1);
    chk("midrst_pen", pen_a, 0);
    chk("midrst_clrn", clrn_a, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0; #1;
    chk("midrst_clrn_held", clrn_a, 0);
    chk("midrst_no_done", dones_a - d0, 0);
    @(negedge clk);
    chk("midrst_clrn_rel", clrn_a, 1);
    chk("midrst_idle", busy_a, 0);
    hexs = 32'h89AB_CDEF;
    push8(64'h80908883_C6A1868E);
    frame_a("after_rst");

    for (cnt = 0; cnt < 600 && !done_b; cnt++) @(negedge clk);
    chk("b_refresh_seen", done_b, 1);
    for (int k = 0; k < 2; k++) begin
      for (cnt = 1; cnt < 600; cnt++) begin
        @(posedge clk); @(negedge clk);
        if (done_b) break;
      end
      chk("b_refresh_period", cnt, 256);
    end
    @(negedge clk); start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    prev_b = 1'b1; nr = 0; t_first = 0; t_second = 0; t_last = 0;
    for (cnt = 1; cnt < 600; cnt++) begin
      @(posedge clk); @(negedge clk);
      if (!prev_b && sclk_b) begin
        nr++;
        if (nr == 1) t_first = cnt;
        if (nr == 2) t_second = cnt;
        t_last = cnt;
      end
      prev_b = sclk_b;
      if (done_b) break;
    end
    chk("b_done_latency", cnt, 1 + 16*8*1);
    chk("b_rises", nr, 64);
    chk("b_bit_period", t_second - t_first, 2);
    chk("b_frame_span", t_last - t_first, 126);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
